// File: rtl/cpu_run_controller.sv
// Run controller for cpu_top. It sequences the CPU reset and watches for halt.
// At halt it captures the result and checks it against an expected value.
// It also counts RUN cycles and stops the run with a watchdog timeout.
module cpu_run_controller #(
  parameter int unsigned DATA_W       = 16,
  parameter int unsigned CYCLE_W      = 16,
  parameter int unsigned RESET_CYCLES = 1,
  parameter int unsigned TIMEOUT      = 1000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cpu_halt,
  input  logic [DATA_W-1:0]  cpu_result,
  input  logic [DATA_W-1:0]  expected,
  input  logic               check_en,
  output logic               cpu_reset,
  output logic               running,
  output logic               done,
  output logic               pass,
  output logic               fail,
  output logic               timeout,
  output logic [CYCLE_W-1:0] cycle_count,
  output logic [DATA_W-1:0]  result_q
);

  // hold_cnt only has to reach RESET_CYCLES-1.
  localparam int unsigned HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [CYCLE_W-1:0] CNT_MAX    = '1;
  localparam logic [CYCLE_W-1:0] TMO_LAST   = CYCLE_W'(TIMEOUT - 1);
  localparam logic [CYCLE_W-1:0] TMO_VAL    = CYCLE_W'(TIMEOUT);
  localparam logic               TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_HOLD,
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic              restart;

  // A start request is honoured in every state except HOLD.
  always_comb begin
    restart = start && (state != S_HOLD);
  end

  // Run sequencing, capture, cycle counting and the watchdog.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_HOLD;
      hold_cnt    <= '0;
      cpu_reset   <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      result_q    <= '0;
    end else if (restart) begin
      // Abort the run: go back to HOLD and clear the flags. result_q keeps its value.
      state       <= S_HOLD;
      hold_cnt    <= '0;
      cpu_reset   <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
    end else begin
      case (state)
        S_HOLD: begin
          cpu_reset <= 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state       <= S_RUN;
            hold_cnt    <= '0;
            cpu_reset   <= 1'b0;
            running     <= 1'b1;
            cycle_count <= '0;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end
        S_RUN: begin
          if (cpu_halt) begin
            // Halt beats the watchdog. The count does not step on the halt edge.
            state    <= S_HALTED;
            running  <= 1'b0;
            done     <= 1'b1;
            result_q <= cpu_result;
            pass     <= check_en && (cpu_result == expected);
            fail     <= check_en && (cpu_result != expected);
          end else if (TIMEOUT_EN && (cycle_count == TMO_LAST)) begin
            state       <= S_TIMEOUT;
            running     <= 1'b0;
            done        <= 1'b1;
            timeout     <= 1'b1;
            cycle_count <= TMO_VAL;
          end else if (cycle_count != CNT_MAX) begin
            cycle_count <= cycle_count + CYCLE_W'(1);
          end
        end
        S_HALTED, S_TIMEOUT: begin
          // Outputs stay frozen until start or reset.
          cpu_reset <= 1'b0;
        end
        default: begin
          state <= S_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller. It drives three instances with different
// parameter sets from one shared stimulus stream. Each instance is checked
// every cycle against its own behavioural model, and directed checks pin
// the expected values at key points.
module tb_cpu_run_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start, cpu_halt, check_en;
  logic [15:0] cpu_result, expected;

  always #5 clk = ~clk;

  // m: RESET_CYCLES=3, TIMEOUT=1000. t: RESET_CYCLES=3, TIMEOUT=10.
  // s: CYCLE_W=4, RESET_CYCLES=1, TIMEOUT=0.
  logic        m_cpu_reset, m_running, m_done, m_pass, m_fail, m_timeout;
  logic [15:0] m_cycle_count, m_result_q;
  logic        t_cpu_reset, t_running, t_done, t_pass, t_fail, t_timeout;
  logic [15:0] t_cycle_count, t_result_q;
  logic        s_cpu_reset, s_running, s_done, s_pass, s_fail, s_timeout;
  logic [3:0]  s_cycle_count;
  logic [15:0] s_result_q;

  cpu_run_controller #(.DATA_W(16), .CYCLE_W(16), .RESET_CYCLES(3), .TIMEOUT(1000)) u_m (
    .clk(clk), .reset(reset), .start(start), .cpu_halt(cpu_halt),
    .cpu_result(cpu_result), .expected(expected), .check_en(check_en),
    .cpu_reset(m_cpu_reset), .running(m_running), .done(m_done), .pass(m_pass),
    .fail(m_fail), .timeout(m_timeout), .cycle_count(m_cycle_count), .result_q(m_result_q));

  cpu_run_controller #(.DATA_W(16), .CYCLE_W(16), .RESET_CYCLES(3), .TIMEOUT(10)) u_t (
    .clk(clk), .reset(reset), .start(start), .cpu_halt(cpu_halt),
    .cpu_result(cpu_result), .expected(expected), .check_en(check_en),
    .cpu_reset(t_cpu_reset), .running(t_running), .done(t_done), .pass(t_pass),
    .fail(t_fail), .timeout(t_timeout), .cycle_count(t_cycle_count), .result_q(t_result_q));

  cpu_run_controller #(.DATA_W(16), .CYCLE_W(4), .RESET_CYCLES(1), .TIMEOUT(0)) u_s (
    .clk(clk), .reset(reset), .start(start), .cpu_halt(cpu_halt),
    .cpu_result(cpu_result), .expected(expected), .check_en(check_en),
    .cpu_reset(s_cpu_reset), .running(s_running), .done(s_done), .pass(s_pass),
    .fail(s_fail), .timeout(s_timeout), .cycle_count(s_cycle_count), .result_q(s_result_q));

  int n_total = 0;
  int n_bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Run model: phase 0 = reset hold, 1 = running, 2 = finished.
  typedef struct {
    int          rc;
    int          tmo;
    int          cw;
    int          phase;
    int          hold_left;
    int          cnt;
    bit          pass;
    bit          fail;
    bit          tmo_hit;
    logic [15:0] res;
  } mdl_t;

  function automatic mdl_t m_init(input int rc, input int tmo, input int cw);
    mdl_t m;
    m.rc = rc; m.tmo = tmo; m.cw = cw;
    m.phase = 0; m.hold_left = rc; m.cnt = 0;
    m.pass = 0; m.fail = 0; m.tmo_hit = 0; m.res = '0;
    return m;
  endfunction

  function automatic mdl_t m_restart(input mdl_t m_in);
    mdl_t m = m_in;
    m.phase = 0; m.hold_left = m.rc; m.cnt = 0;
    m.pass = 0; m.fail = 0; m.tmo_hit = 0;
    return m;
  endfunction

  function automatic mdl_t m_step(input mdl_t m_in, input bit st, input bit h,
                                  input logic [15:0] r, input logic [15:0] e, input bit ce);
    mdl_t m = m_in;
    if (m.phase == 0) begin
      m.hold_left = m.hold_left - 1;
      if (m.hold_left == 0) begin
        m.phase = 1;
        m.cnt = 0;
      end
    end else if (st) begin
      m = m_restart(m);
    end else if (m.phase == 1) begin
      if (h) begin
        m.phase = 2;
        m.res = r;
        m.pass = ce && (r == e);
        m.fail = ce && (r != e);
      end else if (m.tmo != 0 && m.cnt + 1 == m.tmo) begin
        m.phase = 2;
        m.cnt = m.tmo;
        m.tmo_hit = 1;
      end else if (m.cnt < (1 << m.cw) - 1) begin
        m.cnt = m.cnt + 1;
      end
    end
    return m;
  endfunction

  mdl_t mm = m_init(3, 1000, 16);
  mdl_t mt = m_init(3, 10, 16);
  mdl_t ms = m_init(1, 0, 4);

  // Advance the models on the same events that the DUTs see.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mm = m_init(3, 1000, 16);
      mt = m_init(3, 10, 16);
      ms = m_init(1, 0, 4);
    end else begin
      mm = m_step(mm, start, cpu_halt, cpu_result, expected, check_en);
      mt = m_step(mt, start, cpu_halt, cpu_result, expected, check_en);
      ms = m_step(ms, start, cpu_halt, cpu_result, expected, check_en);
    end
  end

  task automatic cmp(input string tag, input mdl_t m, input logic cr, input logic rn,
                     input logic dn, input logic ps, input logic fl, input logic to,
                     input logic [15:0] cnt, input logic [15:0] rq);
    chk({tag, ".cpu_reset"}, cr, 32'(m.phase == 0));
    chk({tag, ".running"}, rn, 32'(m.phase == 1));
    chk({tag, ".done"}, dn, 32'(m.phase == 2));
    chk({tag, ".pass"}, ps, 32'(m.pass));
    chk({tag, ".fail"}, fl, 32'(m.fail));
    chk({tag, ".timeout"}, to, 32'(m.tmo_hit));
    chk({tag, ".cycle_count"}, cnt, 32'(m.cnt));
    chk({tag, ".result_q"}, rq, 32'(m.res));
  endtask

  // Compare all three instances against their models every cycle, away from the active edge.
  always @(negedge clk) begin
    cmp("m", mm, m_cpu_reset, m_running, m_done, m_pass, m_fail, m_timeout, m_cycle_count, m_result_q);
    cmp("t", mt, t_cpu_reset, t_running, t_done, t_pass, t_fail, t_timeout, t_cycle_count, t_result_q);
    cmp("s", ms, s_cpu_reset, s_running, s_done, s_pass, s_fail, s_timeout, 16'(s_cycle_count), s_result_q);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic restart();
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
  endtask

  initial begin
    start = 1'b0; cpu_halt = 1'b0; check_en = 1'b0;
    cpu_result = '0; expected = '0;
    step(); step();
    chk("rst_cpu_reset", m_cpu_reset, 1);
    chk("rst_running", m_running, 0);
    chk("rst_count", m_cycle_count, 0);
    chk("rst_result_q", m_result_q, 0);
    reset = 1'b0;

    // Three hold clocks after reset release, then RUN from zero.
    step(); chk("t1_hold1", m_cpu_reset, 1);
    step(); chk("t1_hold2", m_cpu_reset, 1);
    step(); chk("t1_release", m_cpu_reset, 0);
    chk("t1_running", m_running, 1);
    chk("t1_count0", m_cycle_count, 0);

    // Watchdog trips on the 10th RUN edge.
    repeat (9) step();
    chk("t4_pre_timeout", t_timeout, 0);
    chk("t4_pre_count", t_cycle_count, 9);
    step();
    chk("t4_timeout", t_timeout, 1);
    chk("t4_count", t_cycle_count, 10);
    chk("t4_done", t_done, 1);
    chk("t4_running", t_running, 0);

    // With the watchdog disabled, the 4-bit counter saturates.
    repeat (10) step();
    chk("t6_sat", s_cycle_count, 4'hF);
    chk("t6_sat_running", s_running, 1);
    chk("m_count20", m_cycle_count, 20);

    // A start request in HOLD is ignored and does not stretch the hold.
    start = 1'b1;
    step();
    chk("t5_abort_reset", m_cpu_reset, 1);
    chk("t5_abort_count", m_cycle_count, 0);
    chk("t5_abort_tmo", t_timeout, 0);
    chk("t5_abort_done", t_done, 0);
    step();
    start = 1'b0;
    chk("t5_hold_b", m_cpu_reset, 1);
    step(); chk("t5_hold_c", m_cpu_reset, 1);
    step(); chk("t5_hold_end", m_cpu_reset, 0);
    chk("t5_run", m_running, 1);

    // Halt arrives on the same edge the watchdog would trip.
    repeat (9) step();
    cpu_halt = 1'b1; cpu_result = 16'h00FF; expected = 16'h00FF; check_en = 1'b1;
    step();
    cpu_halt = 1'b0;
    chk("t4b_timeout", t_timeout, 0);
    chk("t4b_done", t_done, 1);
    chk("t4b_count", t_cycle_count, 9);
    chk("t4b_pass", t_pass, 1);

    // Halt after 42 RUN edges with a matching result.
    restart();
    repeat (42) step();
    cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    chk("t2_done", m_done, 1);
    chk("t2_pass", m_pass, 1);
    chk("t2_fail", m_fail, 0);
    chk("t2_result", m_result_q, 16'h00FF);
    chk("t2_count", m_cycle_count, 42);
    cpu_result = 16'h1234; cpu_halt = 1'b1;
    repeat (20) step();
    cpu_halt = 1'b0;
    chk("t2_frozen_pass", m_pass, 1);
    chk("t2_frozen_result", m_result_q, 16'h00FF);
    chk("t2_frozen_count", m_cycle_count, 42);

    // Mismatching result.
    restart();
    repeat (7) step();
    cpu_result = 16'h00FF; expected = 16'h0100; cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    chk("t3_fail", m_fail, 1);
    chk("t3_pass", m_pass, 0);
    chk("t3_done", m_done, 1);
    chk("t3_count", m_cycle_count, 7);

    // Abort at count 5. Flags clear and a new run starts from zero.
    restart();
    repeat (5) step();
    chk("t5_count5", m_cycle_count, 5);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("t5b_cpu_reset", m_cpu_reset, 1);
    chk("t5b_fail_clr", m_fail, 0);
    chk("t5b_done_clr", m_done, 0);
    chk("t5b_count", m_cycle_count, 0);
    repeat (3) step();

    // Halt on the first RUN edge with checking off.
    check_en = 1'b0; cpu_result = 16'h0ABC; expected = 16'h0ABC; cpu_halt = 1'b1;
    step();
    cpu_halt = 1'b0;
    chk("t3b_done", m_done, 1);
    chk("t3b_pass", m_pass, 0);
    chk("t3b_fail", m_fail, 0);
    chk("t3b_count", m_cycle_count, 0);
    chk("t3b_result", m_result_q, 16'h0ABC);

    // Async reset between edges in the middle of a run.
    restart();
    repeat (4) step();
    chk("t6_pre_count", m_cycle_count, 4);
    chk("t6_pre_result", m_result_q, 16'h0ABC);
    reset = 1'b1;
    #1;
    chk("t6_async_cpu_reset", m_cpu_reset, 1);
    chk("t6_async_running", m_running, 0);
    chk("t6_async_count", m_cycle_count, 0);
    chk("t6_async_result", m_result_q, 0);
    chk("t6_async_done", m_done, 0);
    step(); step();
    reset = 1'b0;
    repeat (5) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
